dec_tree_seq: RTL and testbench
===============================

// Module: dec_tree_seq
// PURPOSE
//  Parametrised registered one-hot decoder. Generalises the fixed 3-to-8 / 2-to-4 tree to
//  NUM_OUT outputs, with a valid/ready handshake on both sides, an enable/active-low option
//  and a SWEEP mode that walks the one-hot output across all lines.
//  Feeds chip-select, row-select and LED-scan logic in the misc projects.
// PARAMETERS
//  NUM_OUT    8  number of one-hot output lines (2..256); need not be a power of 2
//  SEL_W      $clog2(NUM_OUT) (localparam, derived)  select width
//  ACT_LOW    0  1: outputs active-low (inactive lines = 1), idle output all-ones
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        command valid
//  in_ready   out  1        block can accept command
//  in_sel     in   SEL_W    line to select / sweep start line
//  in_mode    in   1        0 = SINGLE decode, 1 = SWEEP
//  in_en      in   1        0: command produces an all-inactive output word
//  out_valid  out  1        out_dec valid
//  out_ready  in   1        downstream accepts out_dec
//  out_dec    out  NUM_OUT  one-hot (or one-cold when ACT_LOW) decode word
//  out_last   out  1        marks final word of a command (always 1 in SINGLE)
// BEHAVIOUR
//  - Reset: out_valid=0, out_last=0, out_dec=inactive (0s, or 1s if ACT_LOW), FSM=IDLE, count=0.
//  - Transfer on either side when valid && ready, sampled at rising clk.
//  - FSM IDLE: in_ready = !out_valid || out_ready (single output register, no bubble).
//    SINGLE accept: next cycle out_valid=1, out_dec=decode(in_sel), out_last=1; latency 1.
//    SWEEP accept: go to SWEEP; emit NUM_OUT words decode(in_sel), decode(in_sel+1), ...
//  - FSM SWEEP: in_ready=0; index advances only on out transfer; index wraps NUM_OUT-1 -> 0;
//    out_last=1 on word NUM_OUT; on that word's transfer return to IDLE (new command may be
//    accepted that same cycle, giving back-to-back output with no gap).
//  - out_dec/out_last held stable while out_valid && !out_ready.
//  - in_sel >= NUM_OUT: SINGLE gives all-inactive word; SWEEP starts at line 0.
//  - in_en=0: every word of the command is all-inactive; word count/out_last unchanged.
//  - rst mid-sweep: abort immediately, all outputs to reset values next cycle.
// CONFIGURATION
//  DEC_ERR_FLAG_EN defined: extra output port out_err (1 bit, reset 0), registered with
//    out_dec; 1 for a SINGLE command with in_sel >= NUM_OUT, else 0.
//  Undefined: port absent; out-of-range handling as above, silent.
// STRUCTURE
//  Package dec_pkg: typedef enum {DEC_IDLE, DEC_SWEEP} dec_state_t; typedef enum logic
//    {DEC_SINGLE=0, DEC_SWEEP_M=1} dec_mode_t; function onehot_dec(sel, num).
//  Sub-module dec2to4_en: combinational 2-to-4 with enable; generate-tree of leaves forms
//    the decode; one pad stage for odd SEL_W; unused top lines masked above NUM_OUT.
// TESTING
//  1 rst held 3 cyc -> out_valid=0, out_dec=8'h00 (ACT_LOW=1: 8'hFF).
//  2 SINGLE sel=5, out_ready=1 -> next cyc out_dec=8'h20, out_last=1; back-to-back 0..7 one/cyc.
//  3 SWEEP sel=6 -> 8'h40,80,01,02,04,08,10,20; out_last only on 8'h20; in_ready=0 throughout.
//  4 SWEEP with out_ready toggled 1010 -> each word held while stalled, none skipped/repeated.
//  5 NUM_OUT=6, SINGLE sel=7 -> out_dec=6'h00; DEC_ERR_FLAG_EN: out_err=1; sel=5 -> 6'h20, err=0.
//  6 rst asserted on 3rd sweep word -> next cyc out_valid=0, in_ready=1, new SINGLE sel=1 -> 8'h02.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec_tree_seq one-hot decoder.
package dec_pkg;

  typedef enum logic {DEC_IDLE = 1'b0, DEC_SWEEP = 1'b1} dec_state_t;
  typedef enum logic {DEC_SINGLE = 1'b0, DEC_SWEEP_M = 1'b1} dec_mode_t;

  localparam int unsigned DEC_MAX_OUT = 256;

  // Reference one-hot of sel over num lines; all-zero when sel is out of range.
  function automatic logic [DEC_MAX_OUT-1:0] onehot_dec(input logic [8:0] sel,
                                                        input int unsigned num);
    logic [DEC_MAX_OUT-1:0] w;
    w = '0;
    if (32'(sel) < num) begin
      w[sel[7:0]] = 1'b1;
    end else begin
      w = '0;
    end
    return w;
  endfunction

endpackage

// File: rtl/dec2to4_en.sv
// Combinational 2-to-4 decoder with enable; one level of the decode tree.
module dec2to4_en (
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic [3:0] dec_o
);

  // One-hot of sel_i when enabled, otherwise all zero.
  always_comb begin
    dec_o = 4'b0000;
    if (en_i) begin
      dec_o[sel_i] = 1'b1;
    end else begin
      dec_o = 4'b0000;
    end
  end

endmodule

// File: rtl/dec_tree_seq.sv
// Registered one-hot decoder with valid/ready handshake, SINGLE and SWEEP modes.
// Optional DEC_ERR_FLAG_EN adds out_err flagging out-of-range SINGLE selects.
module dec_tree_seq
  import dec_pkg::*;
#(
  parameter  int NUM_OUT = 8,
  parameter  int ACT_LOW = 0,
  localparam int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_mode,
  input  logic               in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_dec,
`ifdef DEC_ERR_FLAG_EN
  output logic               out_err,
`endif
  output logic               out_last
);

  localparam int PSEL_W = SEL_W + (SEL_W % 2);
  localparam int LVLS   = PSEL_W / 2;
  localparam int LEAF_W = 1 << PSEL_W;
  localparam logic [NUM_OUT-1:0] INACT     = (ACT_LOW != 0) ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};
  localparam logic [SEL_W:0]     NUM_OUT_W = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W:0]     CNT_ONE   = (SEL_W+1)'(1);
  localparam logic [SEL_W-1:0]   LAST_IDX  = SEL_W'(NUM_OUT - 1);

  dec_state_t         state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W:0]     cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [NUM_OUT-1:0] out_dec_q, out_dec_d;
`ifdef DEC_ERR_FLAG_EN
  logic               err_q, err_d;
`endif

  dec_mode_t          mode_s;
  logic               in_ready_s, in_xfer_s, out_xfer_s, sel_oor_s;
  logic [SEL_W-1:0]   idx_next_s, dec_line_s;
  logic               dec_en_s;
  logic [PSEL_W-1:0]  psel_s;
  logic [3:0]         lvl_dec_s [LVLS];
  logic [LEAF_W-1:0]  leaf_s;
  logic [NUM_OUT-1:0] dec_word_s;

  assign mode_s     = dec_mode_t'(in_mode);
  assign in_xfer_s  = in_valid && in_ready_s;
  assign out_xfer_s = out_valid_q && out_ready;
  assign sel_oor_s  = {1'b0, in_sel} >= NUM_OUT_W;
  assign idx_next_s = (idx_q == LAST_IDX) ? {SEL_W{1'b0}} : idx_q + SEL_W'(1);

  // Accept readiness; in SWEEP the last word's transfer frees the slot for a new command.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      DEC_IDLE:  in_ready_s = !out_valid_q || out_ready;
      DEC_SWEEP: in_ready_s = out_last_q && out_ready;
      default:   in_ready_s = 1'b0;
    endcase
  end

  // Select the line/enable feeding the decode tree for the next registered word.
  always_comb begin
    dec_line_s = idx_next_s;
    dec_en_s   = en_q;
    if (in_xfer_s) begin
      dec_en_s = in_en;
      if (mode_s == DEC_SWEEP_M && sel_oor_s) begin
        dec_line_s = {SEL_W{1'b0}};
      end else begin
        dec_line_s = in_sel;
      end
    end else begin
      dec_line_s = idx_next_s;
      dec_en_s   = en_q;
    end
  end

  if (PSEL_W > SEL_W) begin : g_pad
    assign psel_s = {1'b0, dec_line_s};
  end else begin : g_nopad
    assign psel_s = dec_line_s;
  end

  // Each level predecodes two select bits; only the top level carries the enable.
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    dec2to4_en u_leaf (
      .en_i  ((l == 0) ? dec_en_s : 1'b1),
      .sel_i (psel_s[PSEL_W-2-2*l +: 2]),
      .dec_o (lvl_dec_s[l])
    );
  end

  // Combine level predecodes: leaf line i is hot when every level selects i's digit.
  always_comb begin
    logic       hit_v;
    logic [1:0] dig_v;
    hit_v  = 1'b0;
    dig_v  = 2'b00;
    leaf_s = '0;
    for (int i = 0; i < LEAF_W; i++) begin
      hit_v = 1'b1;
      for (int l = 0; l < LVLS; l++) begin
        dig_v = 2'((i >> (2 * (LVLS - 1 - l))) & 3);
        hit_v = hit_v & lvl_dec_s[l][dig_v];
      end
      leaf_s[i] = hit_v;
    end
  end

  if (LEAF_W > NUM_OUT) begin : g_mask
    logic unused_hi_s;
    assign unused_hi_s = |leaf_s[LEAF_W-1:NUM_OUT];
  end

  assign dec_word_s = leaf_s[NUM_OUT-1:0] ^ INACT;

  // Next-state: load a command, advance a sweep on transfer, or drain to idle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_dec_d   = out_dec_q;
`ifdef DEC_ERR_FLAG_EN
    err_d       = err_q;
`endif
    if (in_xfer_s) begin
      out_valid_d = 1'b1;
      out_dec_d   = dec_word_s;
      idx_d       = dec_line_s;
      en_d        = in_en;
      cnt_d       = CNT_ONE;
      if (mode_s == DEC_SWEEP_M) begin
        state_d    = DEC_SWEEP;
        out_last_d = 1'b0;
`ifdef DEC_ERR_FLAG_EN
        err_d      = 1'b0;
`endif
      end else begin
        state_d    = DEC_IDLE;
        out_last_d = 1'b1;
`ifdef DEC_ERR_FLAG_EN
        err_d      = sel_oor_s;
`endif
      end
    end else if (out_xfer_s) begin
      if (state_q == DEC_SWEEP && !out_last_q) begin
        idx_d      = idx_next_s;
        cnt_d      = cnt_q + CNT_ONE;
        out_dec_d  = dec_word_s;
        out_last_d = ((cnt_q + CNT_ONE) == NUM_OUT_W);
      end else begin
        state_d     = DEC_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_dec_d   = INACT;
`ifdef DEC_ERR_FLAG_EN
        err_d       = 1'b0;
`endif
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DEC_IDLE;
      idx_q       <= {SEL_W{1'b0}};
      cnt_q       <= {(SEL_W+1){1'b0}};
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_dec_q   <= INACT;
`ifdef DEC_ERR_FLAG_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_dec_q   <= out_dec_d;
`ifdef DEC_ERR_FLAG_EN
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_dec   = out_dec_q;
`ifdef DEC_ERR_FLAG_EN
  assign out_err   = err_q;
`endif

endmodule

// File: tb/tb_dec_tree_seq.sv
// Self-checking bench for dec_tree_seq: 8-line, 8-line active-low and 6-line instances.
module tb_dec_tree_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_mode, in_en, out_ready;
  logic [2:0] in_sel;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_dec;
  logic       al_in_ready, al_out_valid, al_out_last;
  logic [7:0] al_out_dec;
  logic       s_in_valid, s_in_mode, s_in_en, s_out_ready;
  logic [2:0] s_in_sel;
  logic       s_in_ready, s_out_valid, s_out_last;
  logic [5:0] s_out_dec;
`ifdef DEC_ERR_FLAG_EN
  logic       err, al_err, s_err;
`endif

  dec_tree_seq #(.NUM_OUT(8), .ACT_LOW(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_mode(in_mode), .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_dec(out_dec),
`ifdef DEC_ERR_FLAG_EN
    .out_err(err),
`endif
    .out_last(out_last));

  dec_tree_seq #(.NUM_OUT(8), .ACT_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(al_in_ready), .in_sel(in_sel),
    .in_mode(in_mode), .in_en(in_en), .out_valid(al_out_valid), .out_ready(out_ready),
    .out_dec(al_out_dec),
`ifdef DEC_ERR_FLAG_EN
    .out_err(al_err),
`endif
    .out_last(al_out_last));

  dec_tree_seq #(.NUM_OUT(6), .ACT_LOW(0)) dut6 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sel(s_in_sel),
    .in_mode(s_in_mode), .in_en(s_in_en), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_dec(s_out_dec),
`ifdef DEC_ERR_FLAG_EN
    .out_err(s_err),
`endif
    .out_last(s_out_last));

  // Reference model: queue of words still owed downstream for the 8-line instance.
  typedef struct packed { logic [7:0] w; logic last; } word_t;
  word_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit m_ready();
    return (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready == 1'b1);
  endfunction
  function automatic logic [7:0] m_dec();
    return (exp_q.size() > 0) ? exp_q[0].w : 8'h00;
  endfunction
  function automatic logic m_last();
    return (exp_q.size() > 0) ? exp_q[0].last : 1'b0;
  endfunction

  task automatic push_cmd(input logic [2:0] sel, input logic mode, input logic en);
    int start;
    start = int'(sel);
    if (mode == 1'b0) begin
      exp_q.push_back(word_t'{w: en ? 8'(1 << start) : 8'h00, last: 1'b1});
    end else begin
      for (int i = 0; i < 8; i++)
        exp_q.push_back(word_t'{w: en ? 8'(1 << ((start + i) % 8)) : 8'h00, last: (i == 7)});
    end
  endtask

  // Advance one clock, applying the handshake outcome to the model.
  task automatic tick();
    bit ov, ir;
    ov = exp_q.size() > 0;
    ir = m_ready();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (ov && out_ready) void'(exp_q.pop_front());
      if (in_valid && ir) push_cmd(in_sel, in_mode, in_en);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    #1;
    n_cmp++;
    if ({out_valid, out_last, out_dec} !== {1'b0, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL reset: got %h expected %h", {out_valid, out_last, out_dec}, 10'h000);
    end
    n_cmp++;
    if ({al_out_valid, al_out_dec} !== {1'b0, 8'hFF}) begin
      n_bad++; $display("FAIL reset_al: got %h expected %h", {al_out_valid, al_out_dec}, 9'h0FF);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [10:0] exp_v;
    in_valid = 1'b1; in_mode = 1'b0; in_en = 1'b1; in_sel = 3'd5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_last, out_dec} !== {1'b1, 1'b1, 8'h20}) begin
      n_bad++; $display("FAIL single_sel5: got %h expected %h", {out_valid, out_last, out_dec}, 10'h320);
    end
    for (int s = 0; s < 10; s++) begin
      in_valid = (s < 8); in_sel = 3'(s);
      #1;
      exp_v = {(exp_q.size() > 0), m_last(), m_dec(), m_ready()};
      n_cmp++;
      if ({out_valid, out_last, out_dec, in_ready} !== exp_v) begin
        n_bad++; $display("FAIL single_b2b: got %h expected %h", {out_valid, out_last, out_dec, in_ready}, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_sweep();
    logic [10:0] exp_v;
    logic [7:0]  seen [8];
    logic [7:0]  want [8];
    int          n_seen;
    want = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    n_seen = 0;
    in_valid = 1'b1; in_mode = 1'b1; in_en = 1'b1; in_sel = 3'd6; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      #1;
      exp_v = {(exp_q.size() > 0), m_last(), m_dec(), m_ready()};
      n_cmp++;
      if ({out_valid, out_last, out_dec, in_ready} !== exp_v) begin
        n_bad++; $display("FAIL sweep_cyc: got %h expected %h", {out_valid, out_last, out_dec, in_ready}, exp_v);
      end
      n_cmp++;
      if (al_out_dec !== ~m_dec()) begin
        n_bad++; $display("FAIL sweep_al: got %h expected %h", al_out_dec, ~m_dec());
      end
      if (out_valid && n_seen < 8) begin seen[n_seen] = out_dec; n_seen++; end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= n_seen || seen[i] !== want[i]) begin
        n_bad++; $display("FAIL sweep_seq[%0d]: got %h expected %h", i, (i < n_seen) ? seen[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [10:0] exp_v;
    in_valid = 1'b1; in_mode = 1'b1; in_en = 1'b1; in_sel = 3'($urandom_range(0, 7)); out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 17; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      exp_v = {(exp_q.size() > 0), m_last(), m_dec(), m_ready()};
      n_cmp++;
      if ({out_valid, out_last, out_dec, in_ready} !== exp_v) begin
        n_bad++; $display("FAIL stall_cyc%0d: got %h expected %h", c, {out_valid, out_last, out_dec, in_ready}, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_v;
    in_valid = 1'b1; in_mode = 1'b1; in_en = 1'b1; in_sel = 3'd2; out_ready = 1'b1;
    tick();
    in_mode = 1'b0; in_sel = 3'd3;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (c == 9) begin
        n_cmp++;
        if ({out_valid, out_dec} !== {1'b1, 8'h08}) begin
          n_bad++; $display("FAIL b2b_gap: got %h expected %h", {out_valid, out_dec}, 9'h108);
        end
        in_valid = 1'b0;
      end
      exp_v = {(exp_q.size() > 0), m_last(), m_dec(), m_ready()};
      n_cmp++;
      if ({out_valid, out_last, out_dec, in_ready} !== exp_v) begin
        n_bad++; $display("FAIL b2b_cyc%0d: got %h expected %h", c, {out_valid, out_last, out_dec, in_ready}, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_rst_mid();
    in_valid = 1'b1; in_mode = 1'b1; in_en = 1'b1; in_sel = 3'd0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_last, out_dec} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL rst_mid: got %h expected %h", {out_valid, in_ready, out_last, out_dec}, 11'h200);
    end
    in_valid = 1'b1; in_mode = 1'b0; in_sel = 3'd1;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_last, out_dec} !== {1'b1, 1'b1, 8'h02}) begin
      n_bad++; $display("FAIL rst_then_single: got %h expected %h", {out_valid, out_last, out_dec}, 10'h302);
    end
    tick();
  endtask

  task automatic test_random();
    logic [10:0] exp_v;
    int guard;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_mode   = ($urandom_range(0, 3) == 0);
      in_en     = ($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_v = {(exp_q.size() > 0), m_last(), m_dec(), m_ready()};
      n_cmp++;
      if ({out_valid, out_last, out_dec, in_ready} !== exp_v) begin
        n_bad++; $display("FAIL random_cyc%0d: got %h expected %h", c, {out_valid, out_last, out_dec, in_ready}, exp_v);
      end
      n_cmp++;
      if ({al_out_valid, al_out_dec} !== {exp_v[10], ~m_dec()}) begin
        n_bad++; $display("FAIL random_al%0d: got %h expected %h", c, {al_out_valid, al_out_dec}, {exp_v[10], ~m_dec()});
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin tick(); guard++; end
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL random_drain: got valid=%b owed=%0d expected valid=0 owed=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_n6();
    logic [2:0] t_sel  [5];
    logic       t_mode [5];
    logic       t_en   [5];
    logic [5:0] w;
    int         n, start;
    t_sel  = '{3'd7, 3'd5, 3'd6, 3'd7, 3'd4};
    t_mode = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    t_en   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    s_out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      s_in_valid = 1'b1; s_in_sel = t_sel[t]; s_in_mode = t_mode[t]; s_in_en = t_en[t];
      tick();
      s_in_valid = 1'b0;
      n = t_mode[t] ? 6 : 1;
      start = (t_sel[t] >= 3'd6) ? 0 : int'(t_sel[t]);
      for (int i = 0; i < n; i++) begin
        if (!t_en[t] || (!t_mode[t] && t_sel[t] >= 3'd6)) w = 6'h00;
        else w = 6'(1 << ((start + i) % 6));
        #1;
        n_cmp++;
        if ({s_out_valid, s_out_last, s_out_dec} !== {1'b1, (i == n - 1), w}) begin
          n_bad++; $display("FAIL n6_cmd%0d_w%0d: got %h expected %h", t, i, {s_out_valid, s_out_last, s_out_dec}, {1'b1, (i == n - 1), w});
        end
`ifdef DEC_ERR_FLAG_EN
        n_cmp++;
        if (s_err !== (!t_mode[t] && t_sel[t] >= 3'd6)) begin
          n_bad++; $display("FAIL n6_err%0d: got %b expected %b", t, s_err, (!t_mode[t] && t_sel[t] >= 3'd6));
        end
`endif
        tick();
      end
      #1;
      n_cmp++;
      if (s_out_valid !== 1'b0) begin
        n_bad++; $display("FAIL n6_idle%0d: got %b expected 0", t, s_out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_en = 1'b1; in_sel = 3'd0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_mode = 1'b0; s_in_en = 1'b1; s_in_sel = 3'd0; s_out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_sweep();
    test_stall();
    test_back_to_back();
    test_rst_mid();
    test_random();
    test_n6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
